// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with round-robin arbitration,
// optional packet locking and a one-entry registered output stage.
module stream_mux_rr #(
    parameter int WIDTH        = 32,
    parameter int N_INPUTS     = 4,
    parameter int LOCK_PACKETS = 1,
    parameter int SEL_W        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_INPUTS-1:0]       in_valid,
    output logic [N_INPUTS-1:0]       in_ready,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]       in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel
);

    logic [WIDTH-1:0]    ch_data [N_INPUTS];
    logic [N_INPUTS-1:0] grant;
    logic [SEL_W-1:0]    gsel;
    logic                gany;
    logic                load_en;
    logic                xfer;
    logic [SEL_W-1:0]    last_grant;
    logic [SEL_W-1:0]    lock_ch;
    logic                locked;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign load_en = !out_valid || out_ready;

    // Grant depends only on in_valid and registered state, never on in_ready.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        gsel  = '0;
        gany  = 1'b0;
        if (locked) begin
            if (in_valid[lock_ch]) begin
                gany = 1'b1;
                gsel = lock_ch;
            end
        end else begin
            for (int k = 1; k <= N_INPUTS; k++) begin
                c = (int'(last_grant) + k) % N_INPUTS;
                if (!gany && in_valid[c]) begin
                    gany = 1'b1;
                    gsel = SEL_W'(c);
                end
            end
        end
        if (gany) grant[gsel] = 1'b1;
    end

    assign in_ready = grant & {N_INPUTS{load_en}};
    assign xfer     = gany && load_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_sel    <= '0;
            last_grant <= SEL_W'(N_INPUTS - 1);
            locked     <= 1'b0;
            lock_ch    <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= ch_data[gsel];
            out_last   <= in_last[gsel];
            out_sel    <= gsel;
            last_grant <= gsel;
            if (LOCK_PACKETS != 0) begin
                locked  <= !in_last[gsel];
                lock_ch <= gsel;
            end else begin
                locked  <= 1'b0;
                lock_ch <= '0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Random and directed stimulus on a locking and a non-locking mux instance,
// each compared every cycle against a behavioural model of the stream rules.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [1:0]     ordy;
    logic [N-1:0]   rdy   [2];
    logic           ovld  [2];
    logic [W-1:0]   odat  [2];
    logic           olst  [2];
    logic [1:0]     osel  [2];

    int vectors = 0;
    int misses  = 0;

    // model state per instance (0 = locking, 1 = non-locking)
    bit       m_ov [2];
    bit [W-1:0] m_od [2];
    bit       m_ol [2];
    int       m_os [2];
    int       m_lg [2];
    bit       m_lk [2];
    int       m_lc [2];

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .N_INPUTS(N), .LOCK_PACKETS(1)) u_lk (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(ovld[0]),
        .out_ready(ordy[0]), .out_data(odat[0]), .out_last(olst[0]), .out_sel(osel[0]));

    stream_mux_rr #(.WIDTH(W), .N_INPUTS(N), .LOCK_PACKETS(0)) u_nl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(ovld[1]),
        .out_ready(ordy[1]), .out_data(odat[1]), .out_last(olst[1]), .out_sel(osel[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_os[m] = 0;
            m_lg[m] = N - 1; m_lk[m] = 0; m_lc[m] = 0;
        end
    endtask

    // Which channel the model grants: the locked one, else first valid after the last winner.
    function automatic int mgrant(int m);
        if (m_lk[m]) return in_valid[m_lc[m]] ? m_lc[m] : -1;
        for (int k = 1; k <= N; k++)
            if (in_valid[(m_lg[m] + k) % N]) return (m_lg[m] + k) % N;
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] iv, input logic [N-1:0] il,
                         input logic [N*W-1:0] dat, input logic [1:0] ord, input logic r);
        @(negedge clk);
        in_valid = iv; in_last = il; in_data = dat; ordy = ord; rst = r;
        #1;
        for (int m = 0; m < 2; m++) begin
            int g;
            bit ld;
            logic [N-1:0] er;
            g  = mgrant(m);
            ld = !m_ov[m] || ordy[m];
            er = (ld && g >= 0) ? (N'(1) << g) : '0;
            chk($sformatf("in_ready[%0d]", m), 64'(rdy[m]), 64'(er));
            chk($sformatf("out_valid[%0d]", m), 64'(ovld[m]), 64'(m_ov[m]));
            chk($sformatf("out_data[%0d]", m), 64'(odat[m]), 64'(m_od[m]));
            chk($sformatf("out_last[%0d]", m), 64'(olst[m]), 64'(m_ol[m]));
            chk($sformatf("out_sel[%0d]", m), 64'(osel[m]), 64'(m_os[m]));
            if (rst) continue;
            if (ld && g >= 0) begin
                m_ov[m] = 1;
                m_od[m] = dat[g*W +: W];
                m_ol[m] = il[g];
                m_os[m] = g;
                m_lg[m] = g;
                if (m == 0) begin
                    m_lk[m] = !il[g];
                    m_lc[m] = g;
                end
            end else if (m_ov[m] && ordy[m]) begin
                m_ov[m] = 0;
            end
        end
        if (rst) mreset();
        @(posedge clk);
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    initial begin
        logic [N*W-1:0] fair;
        logic [N*W-1:0] bp;
        rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; ordy = 2'b11;
        repeat (2) @(posedge clk);
        mreset();

        // idle after reset
        repeat (10) cycle('0, '0, '0, 2'b11, 1'b0);

        // fairness: all valid, single-beat packets
        for (int i = 0; i < N; i++) fair[i*W +: W] = 32'h100 + i;
        repeat (10) cycle('1, '1, fair, 2'b11, 1'b0);
        repeat (2) cycle('0, '0, fair, 2'b11, 1'b0);

        // back-pressure on channel 2 only
        for (int c = 0; c < 8; c++) begin
            bp = '0;
            bp[2*W +: W] = 32'hA + (c < 2 ? c : 1);
            cycle(4'b0100, 4'b0100, bp, (c >= 2 && c <= 4) ? 2'b00 : 2'b11, 1'b0);
        end

        // packet on ch1 with a valid gap, ch0/ch3 always valid
        cycle(4'b1011, 4'b0000, rnd_data(), 2'b11, 1'b0);
        cycle(4'b1001, 4'b1001, rnd_data(), 2'b11, 1'b0);
        cycle(4'b1011, 4'b1001, rnd_data(), 2'b11, 1'b0);
        cycle(4'b1011, 4'b1011, rnd_data(), 2'b11, 1'b0);
        repeat (3) cycle(4'b1001, 4'b1001, rnd_data(), 2'b11, 1'b0);

        // reset in the middle of a packet
        cycle(4'b0001, 4'b0000, rnd_data(), 2'b00, 1'b0);
        cycle(4'b0101, 4'b0000, rnd_data(), 2'b00, 1'b1);
        repeat (4) cycle(4'b0101, 4'b0000, rnd_data(), 2'b11, 1'b0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] o;
            o[0] = ($urandom_range(0, 9) < 7);
            o[1] = ($urandom_range(0, 9) < 7);
            cycle(N'($urandom), N'($urandom) & N'($urandom), rnd_data(), o,
                  ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
